dual_boot_ctrl: RTL and testbench

- Sequencer for the MAX10 on-chip dual_boot Avalon-MM slave (remote-update block).
- On a single-cycle request it waits for the IP to be idle, then writes the image-select overwrite, then waits for idle again. After a programmable hold-off it triggers reconfiguration into image 0 or image 1.
- Sits between board-level request logic (debounced KEY or RISC-V CSR write) and the dual_boot instance. Status outputs are suitable for driving LEDs.

---
 rtl/dual_boot_pkg.sv | 38 +++
 rtl/dual_boot_poll.sv | 63 ++++++
 rtl/dual_boot_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_dual_boot_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_boot_pkg.sv
// Shared register map, config-select word layout and sequencer states for the
// MAX10 dual_boot remote-update sequencer.
package dual_boot_pkg;

    localparam logic [2:0] REG_TRIGGER = 3'd0;
    localparam logic [2:0] REG_CFGSEL  = 3'd1;
    localparam logic [2:0] REG_BUSY    = 3'd3;

    localparam int SEL_BIT = 0;
    localparam int OVR_BIT = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_POLL_A,
        S_WAIT_A,
        S_WR_SEL,
        S_POLL_B,
        S_WAIT_B,
        S_HOLDOFF,
        S_TRIG,
        S_DONE,
        S_ERR
    } state_e;

    // Bits needed to hold 0..max_val; never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic logic [31:0] cfgsel_word(input logic img);
        logic [31:0] w;
        w          = '0;
        w[OVR_BIT] = 1'b1;
        w[SEL_BIT] = img;
        return w;
    endfunction

endpackage

// File: rtl/dual_boot_poll.sv
// Busy-register poll helper: read-latency countdown, busy sample and poll
// budget. Shared by both poll phases of the sequencer.
module dual_boot_poll
    import dual_boot_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int MAX_POLLS  = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic poll_en,
    input  logic wait_en,
    input  logic clr,
    input  logic ip_busy,
    output logic not_busy,
    output logic retry,
    output logic timeout
);

    localparam int LW = cnt_width(RD_LATENCY - 1);
    localparam int PW = cnt_width(MAX_POLLS);
    localparam logic [LW-1:0] LAT_LOAD = LW'(RD_LATENCY - 1);
    localparam logic [PW-1:0] POLL_MAX = PW'(MAX_POLLS);

    logic [LW-1:0] lat_q, lat_d;
    logic [PW-1:0] polls_q, polls_d;
    logic          sample;
    logic          budget_left;

    always_comb begin
        lat_d       = lat_q;
        polls_d     = polls_q;
        // readdata is valid on the last wait cycle, when the countdown hits zero
        sample      = wait_en && (lat_q == '0);
        budget_left = (polls_q < POLL_MAX);
        not_busy    = sample && !ip_busy;
        retry       = sample && ip_busy && budget_left;
        timeout     = sample && ip_busy && !budget_left;

        if (poll_en) begin
            lat_d = LAT_LOAD;
        end else if (wait_en && (lat_q != '0)) begin
            lat_d = lat_q - LW'(1);
        end

        if (clr) begin
            polls_d = '0;
        end else if (retry) begin
            polls_d = polls_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_q   <= '0;
            polls_q <= '0;
        end else begin
            lat_q   <= lat_d;
            polls_q <= polls_d;
        end
    end

endmodule

// File: rtl/dual_boot_ctrl.sv
// Sequencer driving the MAX10 dual_boot Avalon-MM slave: poll idle, write the
// image-select overwrite, poll idle, hold off, then trigger reconfiguration.
//
//   state     | meaning
//   IDLE      | waiting for req
//   POLL_A/B  | busy-register read strobe (before / after config_sel write)
//   WAIT_A/B  | read latency, then busy sample
//   WR_SEL    | config_sel overwrite write
//   HOLDOFF   | delay before trigger
//   TRIG      | reconfiguration trigger write
//   DONE/ERR  | finished / poll timeout; req restarts
module dual_boot_ctrl
    import dual_boot_pkg::*;
#(
    parameter int RD_LATENCY     = 2,
    parameter int MAX_POLLS      = 1024,
    parameter int HOLDOFF_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        img_sel,
    output logic [2:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int HW = cnt_width(HOLDOFF_CYCLES);
    localparam logic [HW-1:0] HOLD_LOAD =
        HW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

    state_e        state_q, state_d;
    logic          img_q, img_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [2:0]    addr_q, addr_d;
    logic          read_q, read_d;
    logic          write_q, write_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic poll_en, wait_en, poll_clr;
    logic not_busy, retry, timeout;
    logic unused_rd_hi;

    assign unused_rd_hi = ^avm_readdata[31:1];
    assign poll_en      = (state_q == S_POLL_A) || (state_q == S_POLL_B);
    assign wait_en      = (state_q == S_WAIT_A) || (state_q == S_WAIT_B);

    dual_boot_poll #(
        .RD_LATENCY (RD_LATENCY),
        .MAX_POLLS  (MAX_POLLS)
    ) u_poll (
        .clk      (clk),
        .reset    (reset),
        .poll_en  (poll_en),
        .wait_en  (wait_en),
        .clr      (poll_clr),
        .ip_busy  (avm_readdata[0]),
        .not_busy (not_busy),
        .retry    (retry),
        .timeout  (timeout)
    );

    always_comb begin
        state_d  = state_q;
        img_d    = img_q;
        hold_d   = hold_q;
        poll_clr = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (req) begin
                    img_d    = img_sel;
                    poll_clr = 1'b1;
                    state_d  = S_POLL_A;
                end
            end
            S_POLL_A: state_d = S_WAIT_A;
            S_WAIT_A: begin
                if (not_busy)     state_d = S_WR_SEL;
                else if (retry)   state_d = S_POLL_A;
                else if (timeout) state_d = S_ERR;
            end
            S_WR_SEL: begin
                poll_clr = 1'b1;
                state_d  = S_POLL_B;
            end
            S_POLL_B: state_d = S_WAIT_B;
            S_WAIT_B: begin
                if (not_busy) begin
                    if (HOLDOFF_CYCLES == 0) begin
                        state_d = S_TRIG;
                    end else begin
                        hold_d  = HOLD_LOAD;
                        state_d = S_HOLDOFF;
                    end
                end else if (retry) begin
                    state_d = S_POLL_B;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_HOLDOFF: begin
                if (hold_q == '0) state_d = S_TRIG;
                else              hold_d  = hold_q - HW'(1);
            end
            S_TRIG:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        read_d  = 1'b0;
        write_d = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        case (state_d)
            S_POLL_A, S_POLL_B: begin
                read_d = 1'b1;
                addr_d = REG_BUSY;
            end
            S_WR_SEL: begin
                write_d = 1'b1;
                addr_d  = REG_CFGSEL;
                wdata_d = cfgsel_word(img_d);
            end
            S_TRIG: begin
                write_d = 1'b1;
                addr_d  = REG_TRIGGER;
                wdata_d = 32'h1;
            end
            default: ;
        endcase
        busy_d = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR));
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            img_q   <= 1'b0;
            hold_q  <= '0;
            addr_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            img_q   <= img_d;
            hold_q  <= hold_d;
            addr_q  <= addr_d;
            read_q  <= read_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign avm_address   = addr_q;
    assign avm_read      = read_q;
    assign avm_write     = write_q;
    assign avm_writedata = wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_dual_boot_ctrl.sv
// Bench for dual_boot_ctrl: two instances (no hold-off / 10-cycle hold-off), an
// Avalon busy-register responder and a closed-form schedule model.
`timescale 1ns/1ps
module tb_dual_boot_ctrl;

    localparam int L    = 2;
    localparam int MAXP = 4;
    localparam int H0   = 0;
    localparam int H1   = 10;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic        bsy;
        logic        dn;
        logic        er;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset         [2];
    logic        req           [2];
    logic        img_sel       [2];
    logic [2:0]  avm_address   [2];
    logic        avm_read      [2];
    logic        avm_write     [2];
    logic [31:0] avm_writedata [2];
    logic [31:0] avm_readdata  [2];
    logic        busy          [2];
    logic        done          [2];
    logic        err           [2];

    dual_boot_ctrl #(.RD_LATENCY(L), .MAX_POLLS(MAXP), .HOLDOFF_CYCLES(H0)) dut0 (
        .clk(clk), .reset(reset[0]), .req(req[0]), .img_sel(img_sel[0]),
        .avm_address(avm_address[0]), .avm_read(avm_read[0]), .avm_write(avm_write[0]),
        .avm_writedata(avm_writedata[0]), .avm_readdata(avm_readdata[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0]));

    dual_boot_ctrl #(.RD_LATENCY(L), .MAX_POLLS(MAXP), .HOLDOFF_CYCLES(H1)) dut1 (
        .clk(clk), .reset(reset[1]), .req(req[1]), .img_sel(img_sel[1]),
        .avm_address(avm_address[1]), .avm_read(avm_read[1]), .avm_write(avm_write[1]),
        .avm_writedata(avm_writedata[1]), .avm_readdata(avm_readdata[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1]));

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   chk_en = 1'b0;

    // model of the current request per instance
    bit   has_req [2];
    int   t0      [2];
    int   nba     [2];
    int   nbb     [2];
    logic img_m   [2];
    int   plan_a  [2];
    int   plan_b  [2];

    // busy-register responder
    int   sl_ph  [2];
    int   sl_n   [2];
    logic resp_v [2][8];
    logic resp_b [2][8];

    // per-request monitors for literal checks
    int   mon_acc      [2];
    int   mon_reads    [2];
    int   mon_reads_a  [2];
    int   mon_last_rd  [2];
    int   mon_writes   [2];
    int   mon_trig     [2];
    int   mon_trig_cyc [2];
    bit   mon_cfg_seen [2];
    int   mon_cfg_data [2];

    obs_t a_o, e_o, q_o;
    logic bz;
    int   slot;
    logic [31:0] rdv;
    int   drv_slot;

    function automatic int hold_of(input int k);
        return (k == 0) ? H0 : H1;
    endfunction

    // Expected outputs at cycle c, derived from the request timeline:
    // each poll iteration takes L+1 cycles, busy reads come before the free one.
    function automatic obs_t model(input int k, input int c);
        obs_t e;
        int per, rel, w, sb, trig;
        e   = '0;
        per = L + 1;
        if (!has_req[k]) return e;
        rel = c - t0[k];
        if (nba[k] > MAXP) begin
            if (rel >= 1 + (MAXP + 1) * per) e.er = 1'b1;
            else begin
                e.bsy = 1'b1;
                if ((rel - 1) % per == 0) begin e.rd = 1'b1; e.addr = 3'd3; end
            end
            return e;
        end
        w = 1 + (nba[k] + 1) * per;
        if (rel < w) begin
            e.bsy = 1'b1;
            if ((rel - 1) % per == 0) begin e.rd = 1'b1; e.addr = 3'd3; end
            return e;
        end
        if (rel == w) begin
            e.bsy  = 1'b1;
            e.wr   = 1'b1;
            e.addr = 3'd1;
            e.data = {30'd0, 1'b1, img_m[k]};
            return e;
        end
        if (nbb[k] > MAXP) begin
            if (rel >= w + 1 + (MAXP + 1) * per) e.er = 1'b1;
            else begin
                e.bsy = 1'b1;
                if ((rel - w - 1) % per == 0) begin e.rd = 1'b1; e.addr = 3'd3; end
            end
            return e;
        end
        sb   = w + 1 + (nbb[k] + 1) * per;
        trig = sb + hold_of(k);
        if (rel < sb) begin
            e.bsy = 1'b1;
            if ((rel - w - 1) % per == 0) begin e.rd = 1'b1; e.addr = 3'd3; end
        end else if (rel < trig) begin
            e.bsy = 1'b1;
        end else if (rel == trig) begin
            e.bsy  = 1'b1;
            e.wr   = 1'b1;
            e.addr = 3'd0;
            e.data = 32'h1;
        end else begin
            e.dn = 1'b1;
        end
        return e;
    endfunction

    // Compare, respond and advance the model once per cycle, away from the edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            a_o = {avm_read[k], avm_write[k], avm_address[k], avm_writedata[k],
                   busy[k], done[k], err[k]};
            if (chk_en) begin
                e_o = model(k, cyc);
                checks++;
                if (a_o !== e_o) begin
                    errors++;
                    $display("FAIL cycle_model inst=%0d cyc=%0d got rd=%b wr=%b addr=%0d data=%h busy=%b done=%b err=%b expected rd=%b wr=%b addr=%0d data=%h busy=%b done=%b err=%b",
                             k, cyc, a_o.rd, a_o.wr, a_o.addr, a_o.data, a_o.bsy, a_o.dn, a_o.er,
                             e_o.rd, e_o.wr, e_o.addr, e_o.data, e_o.bsy, e_o.dn, e_o.er);
                end
            end
            if (avm_read[k] === 1'b1) begin
                bz = (sl_ph[k] == 0) ? (sl_n[k] < nba[k]) : (sl_n[k] < nbb[k]);
                sl_n[k]++;
                slot = (cyc + L) % 8;
                resp_v[k][slot] = 1'b1;
                resp_b[k][slot] = bz;
                mon_reads[k]++;
                mon_last_rd[k] = cyc;
                if (!mon_cfg_seen[k]) mon_reads_a[k]++;
            end
            if (avm_write[k] === 1'b1) begin
                mon_writes[k]++;
                if (avm_address[k] == 3'd1) begin
                    sl_ph[k]        = 1;
                    sl_n[k]         = 0;
                    mon_cfg_seen[k] = 1'b1;
                    mon_cfg_data[k] = int'(avm_writedata[k]);
                end
                if (avm_address[k] == 3'd0) begin
                    mon_trig[k]++;
                    mon_trig_cyc[k] = cyc;
                end
            end
            q_o = model(k, cyc);
            if (reset[k]) begin
                has_req[k] = 1'b0;
            end else if (req[k] && !q_o.bsy) begin
                has_req[k]      = 1'b1;
                t0[k]           = cyc;
                nba[k]          = plan_a[k];
                nbb[k]          = plan_b[k];
                img_m[k]        = img_sel[k];
                sl_ph[k]        = 0;
                sl_n[k]         = 0;
                mon_acc[k]      = cyc;
                mon_reads[k]    = 0;
                mon_reads_a[k]  = 0;
                mon_last_rd[k]  = 0;
                mon_writes[k]   = 0;
                mon_trig[k]     = 0;
                mon_trig_cyc[k] = 0;
                mon_cfg_seen[k] = 1'b0;
                mon_cfg_data[k] = 0;
            end
        end
    end

    // Read data: scheduled busy answer exactly L cycles after the read, noise otherwise.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            drv_slot = cyc % 8;
            for (int k = 0; k < 2; k++) begin
                rdv = $urandom();
                if (resp_v[k][drv_slot] === 1'b1) begin
                    rdv[0] = resp_b[k][drv_slot];
                    resp_v[k][drv_slot] = 1'b0;
                end
                avm_readdata[k] = rdv;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse(input int k, input logic img, input int na, input int nb);
        plan_a[k]  = na;
        plan_b[k]  = nb;
        img_sel[k] = img;
        req[k]     = 1'b1;
        step();
        req[k]     = 1'b0;
        img_sel[k] = ~img;
    endtask

    task automatic wait_end(input int k, input string name);
        int n;
        n = 0;
        while (!(done[k] === 1'b1 || err[k] === 1'b1) && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_timeout inst=%0d got no done/err in 300 cycles expected done or err", name, k);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            reset[k] = 1'b1; req[k] = 1'b0; img_sel[k] = 1'b0;
            plan_a[k] = 0; plan_b[k] = 0; has_req[k] = 1'b0;
            t0[k] = 0; nba[k] = 0; nbb[k] = 0; img_m[k] = 1'b0;
            sl_ph[k] = 0; sl_n[k] = 0; avm_readdata[k] = '0;
            mon_acc[k] = 0; mon_reads[k] = 0; mon_reads_a[k] = 0; mon_last_rd[k] = 0;
            mon_writes[k] = 0; mon_trig[k] = 0; mon_trig_cyc[k] = 0;
            mon_cfg_seen[k] = 1'b0; mon_cfg_data[k] = 0;
            for (int s = 0; s < 8; s++) begin
                resp_v[k][s] = 1'b0; resp_b[k][s] = 1'b0;
            end
        end
        repeat (3) step();
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        chk_en   = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_outputs", int'({avm_read[k], avm_write[k], avm_address[k],
                                       busy[k], done[k], err[k]}), 0);
            chk("reset_wdata", int'(avm_writedata[k]), 0);
        end

        // idle IP, no hold-off, image 1
        pulse(0, 1'b1, 0, 0);
        wait_end(0, "t1");
        chk("t1_trig_latency", mon_trig_cyc[0] - mon_acc[0], 8);
        chk("t1_cfg_data", mon_cfg_data[0], 3);
        chk("t1_trig_count", mon_trig[0], 1);
        chk("t1_done", int'(done[0]), 1);

        // three busy reads in the first phase, image 0, restart from DONE
        repeat (2) step();
        pulse(0, 1'b0, 3, 0);
        wait_end(0, "t2");
        chk("t2_reads_phase_a", mon_reads_a[0], 4);
        chk("t2_cfg_data", mon_cfg_data[0], 2);
        chk("t2_done", int'(done[0]), 1);

        // busy stuck: timeout after MAX_POLLS+1 reads, never a write
        pulse(0, 1'b1, 99, 0);
        wait_end(0, "t3");
        repeat (5) step();
        chk("t3_reads", mon_reads[0], 5);
        chk("t3_err", int'(err[0]), 1);
        chk("t3_busy", int'(busy[0]), 0);
        chk("t3_writes", mon_writes[0], 0);

        // ten-cycle hold-off after the phase-B free sample
        pulse(1, 1'b1, 0, 1);
        wait_end(1, "t4");
        chk("t4_holdoff", mon_trig_cyc[1] - (mon_last_rd[1] + L + 1), 10);
        chk("t4_cfg_data", mon_cfg_data[1], 3);

        // req and img_sel toggling during HOLDOFF are ignored
        pulse(1, 1'b0, 0, 0);
        repeat (9) step();
        pulse(1, 1'b1, 0, 0);
        step();
        pulse(1, 1'b1, 2, 2);
        wait_end(1, "t5");
        chk("t5_trig_latency", mon_trig_cyc[1] - mon_acc[1], 18);
        chk("t5_cfg_data", mon_cfg_data[1], 2);
        chk("t5_trig_count", mon_trig[1], 1);

        // reset during WAIT_B, then a clean run
        pulse(1, 1'b1, 0, 0);
        repeat (5) step();
        reset[1] = 1'b1;
        step();
        reset[1] = 1'b0;
        chk("t6_outputs_after_reset", int'({avm_read[1], avm_write[1], avm_address[1],
                                            busy[1], done[1], err[1]}), 0);
        repeat (20) step();
        chk("t6_no_trigger", mon_trig[1], 0);
        pulse(1, 1'b0, 1, 2);
        wait_end(1, "t6");
        chk("t6_trig_latency", mon_trig_cyc[1] - mon_acc[1], 27);
        chk("t6_cfg_data", mon_cfg_data[1], 2);
        chk("t6_done", int'(done[1]), 1);

        // random requests, busy patterns and resets on both instances
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 2; k++) begin
                req[k]     = ($urandom_range(0, 7) == 0);
                img_sel[k] = 1'($urandom_range(0, 1));
                plan_a[k]  = int'($urandom_range(0, 5));
                plan_b[k]  = int'($urandom_range(0, 5));
                reset[k]   = ($urandom_range(0, 199) == 0);
            end
            step();
        end
        for (int k = 0; k < 2; k++) begin
            req[k]   = 1'b0;
            reset[k] = 1'b0;
        end
        repeat (100) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
